// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the round-robin ALU scheduler slice.
//   - OP_W and the opcode values (OP_ADD..OP_XOR) understood by the ALU
//   - is_valid_op(): true for opcodes the ALU implements (000-101)
//   - rsp_state_t: occupancy of the single response register
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_ADD = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB = 3'b001;
   localparam logic [OP_W-1:0] OP_AND = 3'b010;
   localparam logic [OP_W-1:0] OP_OR  = 3'b011;
   localparam logic [OP_W-1:0] OP_NOR = 3'b100;
   localparam logic [OP_W-1:0] OP_XOR = 3'b101;

   // The encoding matches rsp_valid, so the state bit doubles as the flag.
   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_t;

   function automatic logic is_valid_op(input logic [OP_W-1:0] op);
      return (op <= OP_XOR);
   endfunction

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
//   Purely combinational ALU: ADD/SUB/AND/OR/NOR/XOR. Results are truncated
//   to DATA_WIDTH (ADD/SUB wrap, no carry out). Unsupported opcodes give a
//   zero result with err set.
// Ports
//   ina, inb   in   DATA_WIDTH  operands
//   opcode     in   OP_W        operation select
//   result     out  DATA_WIDTH  operation result
//   zero       out  1           result == 0
//   err        out  1           opcode not supported
// ---------------------------------------------------------------------------
module alu
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 4
) (
   input  logic [DATA_WIDTH-1:0] ina,
   input  logic [DATA_WIDTH-1:0] inb,
   input  logic [OP_W-1:0]       opcode,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  zero,
   output logic                  err
);

   // Drop the carry/borrow bit: arithmetic wraps modulo 2^DATA_WIDTH.
   function automatic logic [DATA_WIDTH-1:0] wrap(input logic [DATA_WIDTH:0] v);
      return v[DATA_WIDTH-1:0];
   endfunction

   always_comb begin
      result = '0;
      case (opcode)
         OP_ADD:  result = wrap({1'b0, ina} + {1'b0, inb});
         OP_SUB:  result = wrap({1'b0, ina} - {1'b0, inb});
         OP_AND:  result = ina & inb;
         OP_OR:   result = ina | inb;
         OP_NOR:  result = ~(ina | inb);
         OP_XOR:  result = ina ^ inb;
         default: result = '0;
      endcase
   end

   assign err  = ~is_valid_op(opcode);
   assign zero = (result == '0);

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter. Scans req starting at the internal pointer, upward
//   with wrap; the first asserted request wins. When advance is pulsed the
//   pointer moves to (winner + 1) mod NUM_REQ, otherwise it holds.
// Ports
//   clk, rst_n  in   1        clock, asynchronous active-low reset
//   req         in   NUM_REQ  request vector
//   advance     in   1        winner was accepted this cycle
//   grant       out  NUM_REQ  one-hot grant (zero when no request)
//   idx         out  ID_W     encoded winner index
//   any         out  1        at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((int'(ptr) + k) % NUM_REQ);
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

   // Pointer only moves on an actual transfer, so a stalled winner keeps priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + ID_W'(1);
      end
   end

endmodule

// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
//   Shares one combinational ALU among NUM_REQ requesters. A round-robin
//   arbiter picks one valid requester per cycle; its operands are muxed into
//   the ALU and the result is captured in a single response register tagged
//   with the requester id. Accepts a new op whenever the response register is
//   empty or being drained, giving one op per cycle at full throughput.
// Ports
//   clk, rst_n   in   1                   clock, asynchronous active-low reset
//   req_valid    in   NUM_REQ             per-requester op valid
//   req_ready    out  NUM_REQ             per-requester accept (one-hot or 0)
//   req_ina      in   NUM_REQ*DATA_WIDTH  operand A, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_inb      in   NUM_REQ*DATA_WIDTH  operand B, same packing
//   req_opcode   in   NUM_REQ*OP_W        opcode, requester i at [i*OP_W +: OP_W]
//   rsp_valid    out  1                   response valid
//   rsp_ready    in   1                   response consumer ready
//   rsp_data     out  DATA_WIDTH          registered ALU result
//   rsp_id       out  ID_W                requester that issued the op
//   rsp_zero     out  1                   rsp_data == 0
//   rsp_err      out  1                   opcode was unsupported (110/111)
// ---------------------------------------------------------------------------
module alu_rr_scheduler
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int NUM_REQ    = 4,
   parameter int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_ina,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_inb,
   input  logic [NUM_REQ*OP_W-1:0]       req_opcode,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic [ID_W-1:0]               rsp_id,
   output logic                          rsp_zero,
   output logic                          rsp_err
);

   rsp_state_t state, state_nxt;

   logic [NUM_REQ-1:0]    grant_p0;
   logic [ID_W-1:0]       win_id_p0;
   logic                  any_p0;
   logic                  can_accept;
   logic                  xfer_p0;

   logic [DATA_WIDTH-1:0] ina_p0;
   logic [DATA_WIDTH-1:0] inb_p0;
   logic [OP_W-1:0]       op_p0;
   logic [DATA_WIDTH-1:0] alu_res_p0;
   logic                  alu_zero_p0;
   logic                  alu_err_p0;

   logic [DATA_WIDTH-1:0] rsp_data_p1;
   logic [ID_W-1:0]       rsp_id_p1;
   logic                  rsp_zero_p1;
   logic                  rsp_err_p1;

   // ---- stage p0: arbitration, operand mux, ALU ----
   assign can_accept = (state == RSP_EMPTY) | rsp_ready;
   assign xfer_p0    = can_accept & any_p0;
   assign req_ready  = can_accept ? grant_p0 : '0;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_valid),
      .advance (xfer_p0),
      .grant   (grant_p0),
      .idx     (win_id_p0),
      .any     (any_p0)
   );

   // One-hot AND-OR mux keyed by the grant vector.
   always_comb begin
      ina_p0 = '0;
      inb_p0 = '0;
      op_p0  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_p0[k]) begin
            ina_p0 = req_ina[k*DATA_WIDTH +: DATA_WIDTH];
            inb_p0 = req_inb[k*DATA_WIDTH +: DATA_WIDTH];
            op_p0  = req_opcode[k*OP_W +: OP_W];
         end
      end
   end

   alu #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_alu (
      .ina    (ina_p0),
      .inb    (inb_p0),
      .opcode (op_p0),
      .result (alu_res_p0),
      .zero   (alu_zero_p0),
      .err    (alu_err_p0)
   );

   // ---- stage p1: response register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RSP_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RSP_EMPTY: if (xfer_p0) state_nxt = RSP_FULL;
         RSP_FULL:  if (rsp_ready && !xfer_p0) state_nxt = RSP_EMPTY;
         default:   state_nxt = RSP_EMPTY;
      endcase
   end

   // Payload only loads on a transfer; a stalled response stays stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data_p1 <= '0;
         rsp_id_p1   <= '0;
         rsp_zero_p1 <= 1'b0;
         rsp_err_p1  <= 1'b0;
      end else if (xfer_p0) begin
         rsp_data_p1 <= alu_res_p0;
         rsp_id_p1   <= win_id_p0;
         rsp_zero_p1 <= alu_zero_p0;
         rsp_err_p1  <= alu_err_p0;
      end
   end

   assign rsp_valid = (state == RSP_FULL);
   assign rsp_data  = rsp_data_p1;
   assign rsp_id    = rsp_id_p1;
   assign rsp_zero  = rsp_zero_p1;
   assign rsp_err   = rsp_err_p1;

endmodule
